// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and the multiplier bench.
// Holds the FSM state encoding and the default operand width.
package seq_divider_pkg;

    localparam int DIV_N = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, then
// conditionally subtract the divisor and emit the quotient bit.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   pr,
    input  logic         in_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   pr_next,
    output logic         qbit
);

    logic [N+1:0] pr_wide;
    logic [N:0]   div_ext;
    logic [N:0]   diff;

    // The compare is done one bit wider so pr[N] still takes part.
    // Because pr < divisor, the top bit of pr_wide is always 0.
    assign pr_wide = {pr, in_bit};
    assign div_ext = {1'b0, divisor};
    assign qbit    = (pr_wide >= {1'b0, div_ext});
    assign diff    = pr_wide[N:0] - div_ext;
    assign pr_next = qbit ? diff : pr_wide[N:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor.
// It produces one quotient bit per clock, and each division is one start/done transaction.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dbz
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    state_t         state_reg, state_next;
    logic           busy_next;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   shift_reg;
    logic [N:0]     pr_reg;
    logic [N-1:0]   divisor_reg;
    logic           dbz_work_reg;
    logic           busy_reg, done_reg, dbz_reg;
    logic [W-1:0]   q_reg;
    logic [N-1:0]   r_reg;
    logic [N:0]     pr_next;
    logic           qbit;

    div_step #(.N(N)) u_step (
        .pr      (pr_reg),
        .in_bit  (shift_reg[W-1]),
        .divisor (divisor_reg),
        .pr_next (pr_next),
        .qbit    (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt_reg == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // busy is registered, so it is derived from where the FSM is heading.
        // It stays high through the cycle where done is shown.
        busy_next = (state_next != IDLE) || (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            shift_reg    <= '0;
            pr_reg       <= '0;
            divisor_reg  <= '0;
            dbz_work_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            q_reg        <= '0;
            r_reg        <= '0;
            dbz_reg      <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg    <= dividend;
                        pr_reg       <= '0;
                        cnt_reg      <= CNT_LOAD;
                        divisor_reg  <= divisor;
                        dbz_work_reg <= (divisor == '0);
                    end
                end
                RUN: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    shift_reg <= {shift_reg[W-2:0], qbit};
                    pr_reg    <= pr_next;
                    cnt_reg   <= cnt_reg - 1'b1;
                end
                DONE: begin
                    q_reg   <= dbz_work_reg ? '1 : shift_reg;
                    r_reg   <= dbz_work_reg ? '0 : pr_reg[N-1:0];
                    dbz_reg <= dbz_work_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign q    = q_reg;
    assign r    = r_reg;
    assign dbz  = dbz_reg;

endmodule
